// File: rtl/sprite_blitter.sv
// Sprite erase/draw and full-screen clear engine feeding a VGA pixel-write port.
// Optional macro SPRITE_BLITTER_TRANSPARENCY_EN: sprite pixels equal to TRANSPARENT_COLOR show the background.
module sprite_blitter #(
  parameter int SPR_W    = 4,
  parameter int SPR_H    = 4,
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COLOR_W  = 3,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = '0,
  localparam int N  = SPR_W * SPR_H,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               erase_en_i,
  input  logic [X_W-1:0]     old_x_i,
  input  logic [Y_W-1:0]     old_y_i,
  input  logic [X_W-1:0]     new_x_i,
  input  logic [Y_W-1:0]     new_y_i,
  input  logic               clear_i,
  output logic [X_W-1:0]     bg_x_o,
  output logic [Y_W-1:0]     bg_y_o,
  input  logic [COLOR_W-1:0] bg_color_i,
  output logic [AW-1:0]      spr_addr_o,
  input  logic [COLOR_W-1:0] spr_color_i,
  output logic               plot_o,
  output logic [X_W-1:0]     x_out_o,
  output logic [Y_W-1:0]     y_out_o,
  output logic [COLOR_W-1:0] color_out_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERASE = 3'd1;
  localparam logic [2:0] S_DRAW  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam logic [X_W-1:0] SPR_XL = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0] SPR_YL = Y_W'(SPR_H - 1);
  localparam logic [X_W-1:0] SCR_XL = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SCR_YL = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]   SCR_XN = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_YN = (Y_W+1)'(SCREEN_H);

  logic [2:0]     state_q, state_d;
  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] row_q, row_d;
  logic [AW-1:0]  sidx_q, sidx_d;
  logic [X_W-1:0] ox_q, ox_d, nx_q, nx_d;
  logic [Y_W-1:0] oy_q, oy_d, ny_q, ny_d;
  logic           fcnt_q, fcnt_d;
  logic           done_q, done_d;

  // [0]: stage-1 pixel is on screen, [1]: registered plot strobe
  logic [1:0]         vld_pipe_q;
  logic [X_W-1:0]     s1_x_q, x_q;
  logic [Y_W-1:0]     s1_y_q, y_q;
  logic               s1_spr_q;
  logic [COLOR_W-1:0] color_q, pix_color;

  logic           scan, inb, last_col, last_row;
  logic [X_W-1:0] org_x, lim_x;
  logic [Y_W-1:0] org_y, lim_y;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;

  always_comb begin
    scan  = (state_q == S_ERASE) || (state_q == S_DRAW) || (state_q == S_CLEAR);
    org_x = (state_q == S_ERASE) ? ox_q : (state_q == S_DRAW) ? nx_q : '0;
    org_y = (state_q == S_ERASE) ? oy_q : (state_q == S_DRAW) ? ny_q : '0;
    // One extra bit keeps the carry so wrapped coordinates still clip
    sum_x = {1'b0, org_x} + {1'b0, col_q};
    sum_y = {1'b0, org_y} + {1'b0, row_q};
    inb   = (sum_x < SCR_XN) && (sum_y < SCR_YN);
    lim_x = (state_q == S_CLEAR) ? SCR_XL : SPR_XL;
    lim_y = (state_q == S_CLEAR) ? SCR_YL : SPR_YL;
    last_col = (col_q == lim_x);
    last_row = (row_q == lim_y);
  end

  assign bg_x_o     = scan ? sum_x[X_W-1:0] : '0;
  assign bg_y_o     = scan ? sum_y[Y_W-1:0] : '0;
  assign spr_addr_o = (state_q == S_DRAW) ? sidx_q : '0;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign plot_o     = vld_pipe_q[1];
  assign x_out_o    = x_q;
  assign y_out_o    = y_q;
  assign color_out_o = color_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sidx_d  = sidx_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        col_d  = '0;
        row_d  = '0;
        sidx_d = '0;
        if (clear_i) begin
          state_d = S_CLEAR;
        end else if (start_i) begin
          ox_d = old_x_i;
          oy_d = old_y_i;
          nx_d = new_x_i;
          ny_d = new_y_i;
          state_d = erase_en_i ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE, S_DRAW, S_CLEAR: begin
        if (state_q == S_DRAW) sidx_d = sidx_q + 1'b1;
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            row_d   = '0;
            sidx_d  = '0;
            fcnt_d  = 1'b0;
            state_d = (state_q == S_ERASE) ? S_DRAW : S_FLUSH;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_FLUSH: begin
        fcnt_d = 1'b1;
        if (fcnt_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      sidx_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      fcnt_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sidx_q  <= sidx_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
    end
  end

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign pix_color = (s1_spr_q && (spr_color_i != TRANSPARENT_COLOR)) ? spr_color_i : bg_color_i;
`else
  assign pix_color = s1_spr_q ? spr_color_i : bg_color_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_spr_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], scan && inb};
      if (scan) begin
        s1_x_q   <= sum_x[X_W-1:0];
        s1_y_q   <= sum_y[Y_W-1:0];
        s1_spr_q <= (state_q == S_DRAW);
      end
      if (vld_pipe_q[0]) begin
        x_q     <= s1_x_q;
        y_q     <= s1_y_q;
        color_q <= pix_color;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: stimulus pushes expected plots/done, a monitor pops and compares.
module tb_sprite_blitter;
  localparam int X_W = 9, Y_W = 8, CW = 3, AW = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, erase_en = 1'b0, clear = 1'b0;
  logic [X_W-1:0] old_x = '0, new_x = '0, bg_x, x_out;
  logic [Y_W-1:0] old_y = '0, new_y = '0, bg_y, y_out;
  logic [CW-1:0]  bg_color = '0, spr_color = '0, color_out;
  logic [AW-1:0]  spr_addr;
  logic plot, busy, done;

  sprite_blitter dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .erase_en_i(erase_en),
    .old_x_i(old_x), .old_y_i(old_y), .new_x_i(new_x), .new_y_i(new_y),
    .clear_i(clear), .bg_x_o(bg_x), .bg_y_o(bg_y), .bg_color_i(bg_color),
    .spr_addr_o(spr_addr), .spr_color_i(spr_color), .plot_o(plot),
    .x_out_o(x_out), .y_out_o(y_out), .color_out_o(color_out),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int x; int y; int c; } pix_t;
  pix_t exp_q[$];
  int   done_q[$];
  pix_t e;
  int   cyc = 0, errors = 0, checks = 0, nplots = 0;
  logic [CW-1:0] spr_mem [16];

  // Synchronous ROMs: data one clock after address
  always @(posedge clk) begin
    bg_color  <= CW'((int'(bg_x) + int'(bg_y)) % 8);
    spr_color <= spr_mem[spr_addr];
    cyc       <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (plot) begin
        nplots++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL plot_extra: got (%0d,%0d) c=%0d at cyc %0d, required no plot", x_out, y_out, color_out, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.x != int'(x_out) || e.y != int'(y_out) || e.c != int'(color_out)) begin
            errors++;
            $display("FAIL plot: got (%0d,%0d) c=%0d cyc %0d, required (%0d,%0d) c=%0d cyc %0d",
                     x_out, y_out, color_out, cyc, e.x, e.y, e.c, e.cyc);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_extra: done at cyc %0d, required none", cyc);
        end else begin
          if (done_q[0] != cyc || busy) begin
            errors++;
            $display("FAIL done: cyc %0d busy %0d, required cyc %0d busy 0", cyc, busy, done_q[0]);
          end
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic push_pix(int c, int x, int y, int col);
    pix_t p;
    if (x < 320 && y < 240) begin
      p.cyc = c; p.x = x; p.y = y; p.c = col;
      exp_q.push_back(p);
    end
  endtask

  task automatic wait_done(int lim);
    bit seen = 1'b0;
    for (int n = 0; n < lim && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen within %0d cycles", lim);
    end
  endtask

  // Issue start at the current negedge; expectations are pushed before the edge.
  task automatic issue_sprite(bit er, int ox, int oy, int nx, int ny, output int slots);
    int s, i, col;
    s = cyc; i = 0;
    if (er)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          push_pix(s + 3 + i, ox + c, oy + r, (ox + c + oy + r) % 8);
          i++;
        end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        col = int'(spr_mem[r*4 + c]);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
        if (col == 0) col = (nx + c + ny + r) % 8;
`endif
        push_pix(s + 3 + i, nx + c, ny + r, col);
        i++;
      end
    done_q.push_back(s + i + 3);
    slots = i;
    start = 1'b1; erase_en = er;
    old_x = X_W'(ox); old_y = Y_W'(oy); new_x = X_W'(nx); new_y = Y_W'(ny);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic run_sprite(string name, bit er, int ox, int oy, int nx, int ny, bit poke, int want_plots);
    int n0, slots;
    n0 = nplots;
    issue_sprite(er, ox, oy, nx, ny, slots);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; clear = 1'b1; erase_en = 1'b1;
      old_x = 9'd0; new_x = 9'd0; old_y = 8'd0; new_y = 8'd0;
      @(negedge clk);
      start = 1'b0; clear = 1'b0;
    end
    wait_done(slots + 20);
    check({name, "_plots"}, nplots - n0, want_plots);
    check({name, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    int n0, s, slots;
    for (int i = 0; i < 16; i++) spr_mem[i] = 3'b110;
    #3;
    check("reset_outputs", int'({plot, x_out, y_out, color_out, busy, done, spr_addr, bg_x, bg_y}), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_sprite("move", 1'b1, 10, 20, 11, 20, 1'b0, 32);
    run_sprite("corner", 1'b0, 0, 0, 318, 238, 1'b0, 4);
    run_sprite("carry", 1'b0, 0, 0, 510, 254, 1'b0, 0);
    run_sprite("erase_clip", 1'b1, 317, 237, 0, 0, 1'b0, 25);
    run_sprite("busy_poke", 1'b1, 100, 100, 104, 100, 1'b1, 32);

    // clear and start together: clear wins
    n0 = nplots; s = cyc;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++)
        push_pix(s + 3 + y*320 + x, x, y, (x + y) % 8);
    done_q.push_back(s + 76800 + 3);
    clear = 1'b1; start = 1'b1; erase_en = 1'b1; new_x = 9'd5; new_y = 8'd5;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    wait_done(77000);
    check("clear_plots", nplots - n0, 76800);
    check("clear_queue", exp_q.size(), 0);

    // reset mid-DRAW
    issue_sprite(1'b0, 0, 0, 50, 60, slots);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("abort_outputs", int'({plot, x_out, y_out, color_out, busy, done, spr_addr, bg_x, bg_y}), 0);
    exp_q.delete();
    done_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    run_sprite("after_reset", 1'b1, 50, 60, 52, 61, 1'b0, 32);

    // sprite address 5 transparent colour -> pixel (new_x+1,new_y+1)
    spr_mem[5] = 3'b000;
    run_sprite("transp", 1'b0, 0, 0, 30, 40, 1'b0, 16);

    repeat (5) @(negedge clk);
    check("final_queue", exp_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite drawing engine that sits between the sprite-position logic and the VGA adapter's pixel-write port. On `start` it erases a SPR_W×SPR_H rectangle at the old position by restoring background pixels, then draws the sprite at the new position from a pattern ROM. On `clear` it repaints the whole screen from the background ROM. It streams one pixel per clock through a fixed two-stage pipeline, clips off-screen pixels, and signals completion with a `done` pulse.

## Interface
- SPR_W, 4: sprite width in pixels (≥1)
- SPR_H, 4: sprite height in pixels (≥1)
- X_W, 9: x coordinate width
- Y_W, 8: y coordinate width
- SCREEN_W, 320: visible columns
- SCREEN_H, 240: visible rows
- COLOR_W, 3: pixel colour width
- TRANSPARENT_COLOR, 3'b000: sprite colour treated as transparent (used only under the config macro)
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request erase+draw; sampled only in IDLE
- erase_en  in  1  sampled with `start`; 0 skips the erase phase
- old_x / old_y  in  X_W / Y_W  erase origin, top-left; sampled with `start`
- new_x / new_y  in  X_W / Y_W  draw origin, top-left; sampled with `start`
- clear  in  1  full-screen background fill; sampled only in IDLE
- bg_x / bg_y  out  X_W / Y_W  background ROM address
- bg_color  in  COLOR_W  background ROM data, valid one clock after address
- spr_addr  out  clog2(SPR_W*SPR_H)  sprite ROM address, row*SPR_W+col
- spr_color  in  COLOR_W  sprite ROM data, valid one clock after address
- plot  out  1  pixel write strobe
- x_out / y_out  out  X_W / Y_W  pixel coordinates
- color_out  out  COLOR_W  pixel colour
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, ERASE, DRAW, CLEAR, FLUSH.
- IDLE → CLEAR if `clear`. Otherwise IDLE → ERASE if `start && erase_en`, or IDLE → DRAW if `start && !erase_en`.
- `clear` beats `start` when both are high; that `start` is dropped. In all other states `start` and `clear` are ignored.
- ERASE: scan col 0..SPR_W-1 within row 0..SPR_H-1 (row-major). Address bg at old_x+col, old_y+row. Pixel colour = bg_color. After the last pixel, go to DRAW with no bubble cycle.
- DRAW: same scan. Address bg at new_x+col, new_y+row and spr_addr at row*SPR_W+col. Pixel colour = spr_color. After the last pixel, go to FLUSH.
- CLEAR: scan x 0..SCREEN_W-1, y 0..SCREEN_H-1. Colour = bg_color. Exactly SCREEN_W*SCREEN_H plots. After the last pixel, go to FLUSH.
- FLUSH: hold two cycles to drain the pipeline, then return to IDLE and pulse `done`.
- Coordinates are summed at X_W+1 / Y_W+1 bits.
- Clipping: if the sum ≥ SCREEN_W or ≥ SCREEN_H (including carry-out), the pixel consumes its slot but `plot`=0.
- Origins are latched at `start`. Input changes mid-operation have no effect.

## Timing
- Reset values: plot=0, x_out=0, y_out=0, color_out=0, busy=0, done=0, spr_addr=0, bg_x=0, bg_y=0; state IDLE.
- Reset asserted mid-operation aborts immediately. No further plots occur.
- Pipeline stages:
  - Cycle t: address outputs present the pixel.
  - Cycle t+1: ROM data returns.
  - Edge ending t+1: plot, x_out, y_out and color_out are registered.
  - Result: outputs are valid during cycle t+2.
- Let `start` be sampled at edge k and N = SPR_W*SPR_H.
  - Addresses are issued in cycles k+1 .. k+P, where P = 2N with erase, N without.
  - Plots occur in cycles k+3 .. k+P+2.
  - `done` is high in cycle k+P+3; `busy` is low in that cycle.
- `busy` is high from cycle k+1 through k+P+2.
- `start` may be reasserted in the `done` cycle and is accepted at that edge.
- The clear timeline is the same with P = SCREEN_W*SCREEN_H.
- `plot` is never high in IDLE.

## Configuration
- `SPRITE_BLITTER_TRANSPARENCY_EN` defined: in DRAW, a pixel with spr_color == TRANSPARENT_COLOR outputs bg_color (background of the new position), with the same timing.
- Macro undefined: spr_color is always output, and TRANSPARENT_COLOR is ignored.
- ERASE and CLEAR behaviour is identical in both builds.

## Test plan
- Defaults, bg ROM colour = (x+y)%8, sprite ROM all 3'b110; start with erase_en=1, old (10,20), new (11,20) → 32 plots in cycles k+3..k+34. The first 16 plots are (10..13,20..23) with bg colour; the next 16 are (11..14,20..23) at 3'b110. `done` is high in cycle k+35 only.
- start with erase_en=0, new (318,238) → 16 slots over cycles k+3..k+18. Only (318,238),(319,238),(318,239),(319,239) plot; `done` is high at k+19.
- clear → exactly 76800 plots covering x 0..319 and y 0..239, each once in row-major order with bg colour; then `done`.
- clear and start high together in IDLE → CLEAR runs and start is dropped. A start pulse while busy produces no extra plots.
- Reset asserted 5 cycles into DRAW → all outputs are 0 asynchronously and state is IDLE. A new start afterwards runs a complete sequence.
- With the macro defined and sprite ROM 3'b000 at addr 5 → the pixel at (new_x+1,new_y+1) shows bg_color. Without the macro, that pixel is 3'b000.
